// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Purpose  : Round-robin owner of the 8-digit display writer with a minimum
//            on-screen hold time per owner and live payload tracking.
// Revision : 1.0
// ============================================================================
module display_arbiter #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [127:0] payload,
    output logic [3:0]   ack,
    output logic [7:0]   reg0,
    output logic [7:0]   reg1,
    output logic [15:0]  reg2,
    output logic [1:0]   owner,
    output logic         owner_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state, w_state_next;
    logic [1:0]       r_grant, w_grant_next;
    logic [1:0]       r_last, w_last_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [31:0]      r_disp, w_disp_next;
    logic [3:0]       r_ack, w_ack_next;
    logic [1:0]       r_owner, w_owner_next;
    logic             r_valid, w_valid_next;

    logic [31:0] w_slot [4];
    logic [3:0]  w_others;
    logic [1:0]  w_pick_idle;
    logic [1:0]  w_pick_hold;
    logic        w_hold_done;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign w_slot[gi] = payload[32*gi +: 32];
        end
    endgenerate

    // First set bit in the order base+1, base+2, base+3, base (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign w_others    = req & ~(4'b0001 << r_owner);
    assign w_pick_idle = rr_pick(req, r_last);
    assign w_pick_hold = rr_pick(w_others, r_last);
    assign w_hold_done = (r_cnt == c_hold_max);

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_cnt_next   = r_cnt;
        w_disp_next  = r_disp;
        w_ack_next   = 4'b0000;
        w_owner_next = r_owner;
        w_valid_next = r_valid;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grant_next = w_pick_idle;
                    w_last_next  = w_pick_idle;
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_disp_next  = w_slot[r_grant];
                w_ack_next   = 4'b0001 << r_grant;
                w_owner_next = r_grant;
                w_valid_next = 1'b1;
                w_cnt_next   = '0;
                w_state_next = HOLD;
            end
            HOLD: begin
                if (!w_hold_done) w_cnt_next = r_cnt + CNT_W'(1);
                if (req[r_owner]) w_disp_next = w_slot[r_owner];
                // Owner is last in the search order, so any competitor wins.
                if (w_hold_done) begin
                    if (|w_others) begin
                        w_grant_next = w_pick_hold;
                        w_last_next  = w_pick_hold;
                        w_valid_next = 1'b0;
                        w_state_next = LOAD;
                    end else if (!req[r_owner]) begin
                        w_valid_next = 1'b0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_disp  <= 32'd0;
            r_ack   <= 4'b0000;
            r_owner <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
            r_disp  <= w_disp_next;
            r_ack   <= w_ack_next;
            r_owner <= w_owner_next;
            r_valid <= w_valid_next;
        end
    end

    assign ack         = r_ack;
    assign reg0        = r_disp[31:24];
    assign reg1        = r_disp[23:16];
    assign reg2        = r_disp[15:0];
    assign owner       = r_owner;
    assign owner_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_arbiter
// Purpose  : Scenario bench for display_arbiter with an ack/payload scoreboard.
// Revision : 1.0
// ============================================================================
module tb_display_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] payload;
    logic [3:0]   ack;
    logic [7:0]   reg0;
    logic [7:0]   reg1;
    logic [15:0]  reg2;
    logic [1:0]   owner;
    logic         owner_valid;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    display_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .req(req), .payload(payload), .ack(ack),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .owner(owner), .owner_valid(owner_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] v);
        payload[32*i +: 32] = v;
    endtask

    // Every ack pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            exp_t e;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_ack: got ack=%b owner=%0d", ack, owner);
            end else begin
                e = sb.pop_front();
                if (ack !== (4'b0001 << e.own) || owner !== e.own || {reg0, reg1, reg2} !== e.data)
                    $display("FAIL sb_grant: got ack=%b owner=%0d data=%h, want ack=%b owner=%0d data=%h",
                             ack, owner, {reg0, reg1, reg2}, 4'b0001 << e.own, e.own, e.data);
                else n_pass++;
            end
        end
    end

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 20 && owner_valid; i++) step();
        n_total++;
        if (owner_valid !== 1'b0) $display("FAIL %s_idle: owner_valid=%b want 0", nm, owner_valid);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 4'hF;
        for (int i = 0; i < 4; i++) set_slot(i, 32'h5A5A0000 + i);
        for (int c = 0; c < 3; c++) begin
            step();
            n_total++;
            if ({reg0, reg1, reg2} !== 32'd0 || ack !== 4'd0 || owner !== 2'd0 || owner_valid !== 1'b0)
                $display("FAIL reset_c%0d: regs=%h ack=%b owner=%0d valid=%b want all 0",
                         c, {reg0, reg1, reg2}, ack, owner, owner_valid);
            else n_pass++;
        end
        req   = 4'h0;
        reset = 1'b0;
        step();
        n_total++;
        if (owner_valid !== 1'b0 || {reg0, reg1, reg2} !== 32'd0)
            $display("FAIL reset_idle: valid=%b regs=%h want 0/0", owner_valid, {reg0, reg1, reg2});
        else n_pass++;
    endtask

    task automatic test_single_grant;
        set_slot(1, 32'hABCD1234);
        req = 4'b0010;
        sb.push_back('{own: 2'd1, data: 32'hABCD1234});
        step();
        n_total++;
        if (ack !== 4'b0000 || owner_valid !== 1'b0)
            $display("FAIL single_load: ack=%b valid=%b want 0000/0", ack, owner_valid);
        else n_pass++;
        step();
        n_total++;
        if (reg0 !== 8'hAB || reg1 !== 8'hCD || reg2 !== 16'h1234 || ack !== 4'b0010 ||
            owner !== 2'd1 || owner_valid !== 1'b1)
            $display("FAIL single_show: regs=%h ack=%b owner=%0d valid=%b want abcd1234/0010/1/1",
                     {reg0, reg1, reg2}, ack, owner, owner_valid);
        else n_pass++;
    endtask

    task automatic test_live_update;
        set_slot(1, 32'h11223344);
        step();
        n_total++;
        if (reg0 !== 8'h11 || reg1 !== 8'h22 || reg2 !== 16'h3344 || ack !== 4'b0000 || owner_valid !== 1'b1)
            $display("FAIL live_update: regs=%h ack=%b valid=%b want 11223344/0000/1",
                     {reg0, reg1, reg2}, ack, owner_valid);
        else n_pass++;
        req = 4'b0000;
        wait_idle("live");
    endtask

    task automatic test_round_robin;
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_slot(0, 32'h00C0FFEE);
        set_slot(2, 32'h22BEEF22);
        req = 4'b0101;
        sb.push_back('{own: 2'd0, data: 32'h00C0FFEE});
        sb.push_back('{own: 2'd2, data: 32'h22BEEF22});
        sb.push_back('{own: 2'd0, data: 32'h00C0FFEE});
        step(2);
        n_total++;
        if (owner !== 2'd0 || ack !== 4'b0001 || owner_valid !== 1'b1)
            $display("FAIL rr_first: owner=%0d ack=%b valid=%b want 0/0001/1", owner, ack, owner_valid);
        else n_pass++;
        step(3);
        n_total++;
        if (owner !== 2'd0 || owner_valid !== 1'b1 || ack !== 4'b0000)
            $display("FAIL rr_hold0: owner=%0d valid=%b ack=%b want 0/1/0000", owner, owner_valid, ack);
        else n_pass++;
        step();
        n_total++;
        if (owner_valid !== 1'b0 || ack !== 4'b0000)
            $display("FAIL rr_load: valid=%b ack=%b want 0/0000", owner_valid, ack);
        else n_pass++;
        step();
        n_total++;
        if (owner !== 2'd2 || ack !== 4'b0100 || owner_valid !== 1'b1)
            $display("FAIL rr_second: owner=%0d ack=%b valid=%b want 2/0100/1", owner, ack, owner_valid);
        else n_pass++;
        step(5);
        n_total++;
        if (owner !== 2'd0 || ack !== 4'b0001)
            $display("FAIL rr_third: owner=%0d ack=%b want 0/0001", owner, ack);
        else n_pass++;
        req = 4'b0000;
        wait_idle("rr");
    endtask

    task automatic test_early_drop;
        set_slot(3, 32'hDEADBEEF);
        req = 4'b1000;
        sb.push_back('{own: 2'd3, data: 32'hDEADBEEF});
        step(3);
        req = 4'b0000;
        set_slot(3, 32'h99999999);
        for (int c = 2; c <= 3; c++) begin
            step();
            n_total++;
            if (owner_valid !== 1'b1 || {reg0, reg1, reg2} !== 32'hDEADBEEF)
                $display("FAIL drop_hold_c%0d: valid=%b regs=%h want 1/deadbeef", c, owner_valid, {reg0, reg1, reg2});
            else n_pass++;
        end
        step();
        n_total++;
        if (owner_valid !== 1'b0 || owner !== 2'd3 || {reg0, reg1, reg2} !== 32'hDEADBEEF)
            $display("FAIL drop_idle: valid=%b owner=%0d regs=%h want 0/3/deadbeef",
                     owner_valid, owner, {reg0, reg1, reg2});
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold;
        set_slot(1, 32'hCAFEF00D);
        req = 4'b0010;
        sb.push_back('{own: 2'd1, data: 32'hCAFEF00D});
        step(3);
        reset = 1'b1;
        step();
        n_total++;
        if ({reg0, reg1, reg2} !== 32'd0 || ack !== 4'd0 || owner !== 2'd0 || owner_valid !== 1'b0)
            $display("FAIL midreset: regs=%h ack=%b owner=%0d valid=%b want all 0",
                     {reg0, reg1, reg2}, ack, owner, owner_valid);
        else n_pass++;
        reset = 1'b0;
        sb.push_back('{own: 2'd1, data: 32'hCAFEF00D});
        step();
        n_total++;
        if (ack !== 4'b0000) $display("FAIL midreset_load: ack=%b want 0000", ack);
        else n_pass++;
        step();
        n_total++;
        if (ack !== 4'b0010 || owner !== 2'd1 || owner_valid !== 1'b1 || {reg0, reg1, reg2} !== 32'hCAFEF00D)
            $display("FAIL midreset_regrant: ack=%b owner=%0d valid=%b regs=%h want 0010/1/1/cafef00d",
                     ack, owner, owner_valid, {reg0, reg1, reg2});
        else n_pass++;
        req = 4'b0000;
        wait_idle("midreset");
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'h0;
        payload = '0;
        #1;
        test_reset();
        test_single_grant();
        test_live_update();
        test_round_robin();
        test_early_drop();
        test_reset_mid_hold();
        step(2);
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d grants never acked, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
